// File: rtl/halloween_pkg.sv
// Shared definitions for the effect driver: opcodes, FSM states,
// colour codes and sound/move bit positions.
package halloween_pkg;

    localparam logic [3:0] OP_ON     = 4'h0;
    localparam logic [3:0] OP_RESET  = 4'h1;
    localparam logic [3:0] OP_NOOP   = 4'h2;
    localparam logic [3:0] OP_FOG    = 4'h3;
    localparam logic [3:0] OP_GREEN  = 4'h4;
    localparam logic [3:0] OP_PURPLE = 4'h5;
    localparam logic [3:0] OP_ORANGE = 4'h6;
    localparam logic [3:0] OP_SCREAM = 4'h8;
    localparam logic [3:0] OP_CACKLE = 4'h9;
    localparam logic [3:0] OP_BOO    = 4'hA;
    localparam logic [3:0] OP_WAVE   = 4'hC;
    localparam logic [3:0] OP_JAW    = 4'hD;

    typedef enum logic [1:0] {OFF, IDLE, HOLD} state_t;

    localparam logic [1:0] COL_OFF    = 2'b00;
    localparam logic [1:0] COL_GREEN  = 2'b01;
    localparam logic [1:0] COL_PURPLE = 2'b10;
    localparam logic [1:0] COL_ORANGE = 2'b11;

    localparam int SND_SCREAM = 0;
    localparam int SND_CACKLE = 1;
    localparam int SND_BOO    = 2;
    localparam int MV_WAVE    = 0;
    localparam int MV_JAW     = 1;

    // Opcodes that count as a visible effect (fog, colour, sound, movement)
    function automatic logic op_is_effect(input logic [3:0] o);
        return (o == OP_FOG) || (o == OP_GREEN) || (o == OP_PURPLE) ||
               (o == OP_ORANGE) || (o == OP_SCREAM) || (o == OP_CACKLE) ||
               (o == OP_BOO) || (o == OP_WAVE) || (o == OP_JAW);
    endfunction

endpackage

// File: rtl/effect_driver_timer.sv
// effect_timer: loadable down-counter used for the hold and fog durations.
// expire flags the edge on which the count steps from 1 to 0.
module effect_timer
    import halloween_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    output logic [CNT_W-1:0] value,
    output logic             active,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over load, load wins over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign value  = cnt_q;
    assign active = (cnt_q != '0);
    assign expire = dec && !load && !clear && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/effect_driver.sv
// effect_driver: decodes the effect opcode stream into registered lamp,
// sound, movement and fog drives. Optional macro EFFECT_CNT_EN adds a
// saturating effect_count output.
module effect_driver
    import halloween_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FOG_CYCLES  = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [3:0] op,
    output logic       op_ready,
    output logic       powered,
    output logic [1:0] color,
    output logic [2:0] sound,
    output logic [1:0] move,
    output logic       fog,
    output logic       err
`ifdef EFFECT_CNT_EN
    ,
    output logic [7:0] effect_count
`endif
);

    state_t     state_q, state_d;
    logic       powered_q, powered_d;
    logic [1:0] color_q, color_d;
    logic [2:0] sound_q, sound_d;
    logic [1:0] move_q, move_d;
    logic       fog_q, fog_d;
    logic       err_q, err_d;

    logic             accept;
    logic             hold_load, hold_expire, hold_active;
    logic             fog_load, fog_clear, fog_expire, fog_active;
    logic [CNT_W-1:0] hold_value, fog_value;

    assign op_ready = (state_q != HOLD);
    assign accept   = op_valid && op_ready;

    effect_timer #(.CNT_W(CNT_W)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (CNT_W'(HOLD_CYCLES)),
        .dec      (state_q == HOLD),
        .clear    (1'b0),
        .value    (hold_value),
        .active   (hold_active),
        .expire   (hold_expire)
    );

    // Fog keeps running whatever the hold state; it only stops via RESET/rst
    effect_timer #(.CNT_W(CNT_W)) u_fog_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (fog_load),
        .load_val (CNT_W'(FOG_CYCLES)),
        .dec      (state_q != OFF),
        .clear    (fog_clear),
        .value    (fog_value),
        .active   (fog_active),
        .expire   (fog_expire)
    );

    // Counter contents are only observed through active/expire
    logic unused_timer_bits;
    assign unused_timer_bits = ^{hold_value, fog_value, hold_active, fog_active};

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        powered_d = powered_q;
        color_d   = color_q;
        sound_d   = sound_q;
        move_d    = move_q;
        fog_d     = fog_q;
        err_d     = 1'b0;
        hold_load = 1'b0;
        fog_load  = 1'b0;
        fog_clear = 1'b0;

        if (fog_expire) fog_d = 1'b0;

        case (state_q)
            OFF: begin
                // Everything except ON is swallowed while off
                if (accept && (op == OP_ON)) begin
                    state_d   = IDLE;
                    powered_d = 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_ON, OP_NOOP: ;
                        OP_RESET: begin
                            state_d   = OFF;
                            powered_d = 1'b0;
                            color_d   = COL_OFF;
                            sound_d   = '0;
                            move_d    = '0;
                            fog_d     = 1'b0;
                            fog_clear = 1'b1;
                        end
                        OP_FOG: begin
                            fog_d    = 1'b1;
                            fog_load = 1'b1;
                        end
                        OP_GREEN:  color_d = COL_GREEN;
                        OP_PURPLE: color_d = COL_PURPLE;
                        OP_ORANGE: color_d = COL_ORANGE;
                        OP_SCREAM, OP_CACKLE, OP_BOO: begin
                            sound_d = '0;
                            if (op == OP_SCREAM) sound_d[SND_SCREAM] = 1'b1;
                            if (op == OP_CACKLE) sound_d[SND_CACKLE] = 1'b1;
                            if (op == OP_BOO)    sound_d[SND_BOO]    = 1'b1;
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end
                        OP_WAVE, OP_JAW: begin
                            move_d = '0;
                            if (op == OP_WAVE) move_d[MV_WAVE] = 1'b1;
                            if (op == OP_JAW)  move_d[MV_JAW]  = 1'b1;
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            HOLD: begin
                if (hold_expire) begin
                    sound_d = '0;
                    move_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OFF;
            powered_q <= 1'b0;
            color_q   <= COL_OFF;
            sound_q   <= '0;
            move_q    <= '0;
            fog_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            powered_q <= powered_d;
            color_q   <= color_d;
            sound_q   <= sound_d;
            move_q    <= move_d;
            fog_q     <= fog_d;
            err_q     <= err_d;
        end
    end

    assign powered = powered_q;
    assign color   = color_q;
    assign sound   = sound_q;
    assign move    = move_q;
    assign fog     = fog_q;
    assign err     = err_q;

`ifdef EFFECT_CNT_EN
    logic [7:0] effect_count_q, effect_count_d;

    // Saturating count of effects accepted while idle; RESET clears it
    always_comb begin
        effect_count_d = effect_count_q;
        if (accept && (state_q == IDLE)) begin
            if (op == OP_RESET)
                effect_count_d = '0;
            else if (op_is_effect(op) && (effect_count_q != 8'hFF))
                effect_count_d = effect_count_q + 8'd1;
        end
    end

    // Effect counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) effect_count_q <= '0;
        else     effect_count_q <= effect_count_d;
    end

    assign effect_count = effect_count_q;
`endif

endmodule

// File: doc/effect_driver.md
Name: effect_driver

Overview:
- Sits directly downstream of the opcode-sequencing breadboard stage.
- Consumes the 4-bit effect opcode stream through a valid/ready handshake.
- Turns each opcode into registered actuator drives: colour lamp, sound one-hot, movement one-hot, fog machine.
- Applies power state, timed holds and opcode legality rules.

Parameters:
- HOLD_CYCLES, 4: clock cycles a sound or movement output stays asserted. Legal range ≥1.
- FOG_CYCLES, 8: clock cycles fog stays asserted after a FOG opcode. Legal range ≥1.
- CNT_W, 4: width of the internal hold/fog down-counters. Must hold max(HOLD_CYCLES, FOG_CYCLES).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  upstream presents an opcode
- op  in  4  opcode (encoding below)
- op_ready  out  1  block can accept an opcode this cycle
- powered  out  1  decoration on
- color  out  2  00 off, 01 green, 10 purple, 11 orange
- sound  out  3  one-hot: [0] scream, [1] cackle, [2] boo
- move  out  2  one-hot: [0] wave hands, [1] move jaw
- fog  out  1  fog machine on
- err  out  1  one-cycle pulse on an illegal opcode
- effect_count  out  8  only present with EFFECT_CNT_EN

Behaviour:
- Opcodes:
  - 0000 ON, 0001 RESET, 0010 NOOP, 0011 FOG
  - 0100 GREEN, 0101 PURPLE, 0110 ORANGE
  - 1000 SCREAM, 1001 CACKLE, 1010 BOO
  - 1100 WAVE, 1101 JAW
  - 0111, 1011, 1110, 1111 are illegal
- Transfer occurs when op_valid & op_ready are both high at a rising clk edge.
- All outputs are registered. Effects appear in the cycle after the transfer.
- rst: state=OFF and all outputs 0 immediately; op_ready=1 after release.
- States: OFF, IDLE, HOLD. op_ready = (state != HOLD).
- OFF:
  - ON -> IDLE, powered=1.
  - Every other opcode, including illegal ones, is consumed silently: no err, no output change.
- IDLE, per opcode:
  - ON, NOOP: consumed, no change.
  - RESET: synchronous soft clear. color=00, sound=0, move=0, fog=0, fog counter=0, powered=0 -> OFF.
  - FOG: fog=1, fog counter loaded with FOG_CYCLES. Stays in IDLE.
  - GREEN/PURPLE/ORANGE: color latched. Persists until another colour opcode or RESET.
  - SCREAM/CACKLE/BOO: set the matching sound bit, load the hold counter with HOLD_CYCLES -> HOLD.
  - WAVE/JAW: set the matching move bit, load the hold counter -> HOLD.
  - Illegal: err=1 for exactly one cycle, no other change.
- HOLD:
  - Sound/move asserted for exactly HOLD_CYCLES cycles.
  - The counter decrements each cycle. When it reaches 0, sound and move clear and state returns to IDLE in the same edge.
  - op_ready is low for those HOLD_CYCLES cycles. Minimum spacing between consecutive held effects is HOLD_CYCLES+1 cycles.
- Fog timer runs independently of state:
  - Decrements in IDLE and HOLD; fog clears when it expires.
  - fog is high for exactly FOG_CYCLES cycles.
  - FOG received while fog is active reloads the timer to FOG_CYCLES, extending the fog.
- Only one sound or movement is active at a time. The colour change and fog run concurrently with a hold.
- rst asserted mid-HOLD or mid-fog aborts both immediately; no partial output survives.

Optional Feature:
- Macro: EFFECT_CNT_EN.
- Defined:
  - Adds output effect_count, an 8-bit counter that saturates at 255.
  - Increments on each accepted FOG/colour/sound/movement opcode while in IDLE.
  - Cleared by rst and by the RESET opcode.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package halloween_pkg holds:
  - opcode localparams (ON..JAW)
  - state enum {OFF, IDLE, HOLD}
  - colour codes
  - sound and move bit indices
- One sub-module, effect_timer:
  - loadable CNT_W down-counter with load, value, active and expire signals.
  - Instantiated twice: hold timer and fog timer.

Test Plan (HOLD_CYCLES=4, FOG_CYCLES=8):
1. Release rst, send GREEN -> color stays 00, err=0. Then send ON -> powered=1 in the next cycle, op_ready=1.
2. ON, FOG, then PURPLE 2 cycles later -> fog=1 for exactly 8 cycles, op_ready stays 1, color=10 while fog is still high.
3. SCREAM with CACKLE held valid behind it -> sound=001 for 4 cycles, op_ready=0 for 4 cycles. CACKLE is accepted on the first ready cycle and sound=010 follows with a one-cycle 000 gap.
4. FOG, 5 cycles later FOG again -> fog stays high a total of 13 cycles. RESET at cycle 3 instead -> fog=0, color=00, powered=0 next cycle, state OFF.
5. Send 1111 while powered -> err high for exactly one cycle, all other outputs unchanged. Send 1111 while OFF -> err stays 0.
6. Assert async rst 2 cycles into a JAW hold -> move=00, powered=0 without waiting for clk. After release, op_ready=1. With EFFECT_CNT_EN, effect_count=0.
